// File: rtl/vending_fsm_multi.sv
// Multi-slot vending controller: bounded credit, per-slot stock and prices,
// timed dispense with busy flag, and registered change/dispense pulses.
module vending_fsm_multi #(
    parameter int W          = 32,
    parameter int NUM_DRINKS = 4,
    parameter logic [NUM_DRINKS*W-1:0] PRICES = {32'd25, 32'd20, 32'd15, 32'd10},
    parameter int STOCK_W    = 4,
    parameter int STOCK_INIT = 8,
    parameter int MAX_CREDIT = 100,
    parameter int DISP_CYC   = 2,
    parameter int SEL_W      = $clog2(NUM_DRINKS + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [W-1:0]          coin,
    input  logic [SEL_W-1:0]      drink_choose,
    input  logic                  cancel,
    input  logic                  restock,
    input  logic [SEL_W-1:0]      restock_sel,
    output logic [W-1:0]          total_coin,
    output logic [W-1:0]          change,
    output logic                  change_valid,
    output logic [SEL_W-1:0]      drink_out,
    output logic                  busy,
    output logic                  coin_reject,
    output logic                  sel_err,
    output logic [NUM_DRINKS-1:0] avail,
    output logic [NUM_DRINKS-1:0] sold_out
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_CREDIT = 2'd1;
    localparam logic [1:0] S_DISP   = 2'd2;

    localparam int CNT_W = $clog2(DISP_CYC + 1);
    localparam logic [W:0]         MAX_C      = {1'b0, W'(MAX_CREDIT)};
    localparam logic [STOCK_W-1:0] STOCK_FULL = STOCK_W'(STOCK_INIT);
    localparam logic [CNT_W-1:0]   CNT_INIT   = CNT_W'(DISP_CYC);
    localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);

    logic [1:0]                          state_q, state_d;
    logic [W-1:0]                        credit_q, credit_d;
    logic [W-1:0]                        pend_q, pend_d;
    logic [SEL_W-1:0]                    slot_q, slot_d;
    logic [CNT_W-1:0]                    cnt_q, cnt_d;
    logic [NUM_DRINKS-1:0][STOCK_W-1:0]  stock_q, stock_d;
    logic [W-1:0]                        change_q, change_d;
    logic                                chv_q, chv_d;
    logic [SEL_W-1:0]                    drink_q, drink_d;
    logic                                busy_q, busy_d;
    logic                                rej_q, rej_d;
    logic                                serr_q, serr_d;
    logic [NUM_DRINKS-1:0]               avail_q, avail_d;
    logic [NUM_DRINKS-1:0]               sold_q, sold_d;

    logic         sel_hit;
    logic         stock_nz;
    logic [W-1:0] sel_price;
    logic [W:0]   sum;
    logic         vend_ok;

    always_comb begin
        sel_hit   = 1'b0;
        sel_price = '0;
        stock_nz  = 1'b0;
        for (int k = 0; k < NUM_DRINKS; k++) begin
            if (drink_choose == SEL_W'(k + 1)) begin
                sel_hit   = 1'b1;
                sel_price = PRICES[k*W +: W];
                stock_nz  = stock_q[k] != '0;
            end
        end
    end

    assign sum     = {1'b0, credit_q} + {1'b0, coin};
    assign vend_ok = sel_hit && (credit_q >= sel_price) && stock_nz;

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        pend_d   = pend_q;
        slot_d   = slot_q;
        cnt_d    = cnt_q;
        stock_d  = stock_q;
        change_d = '0;
        chv_d    = 1'b0;
        drink_d  = '0;
        rej_d    = 1'b0;
        serr_d   = 1'b0;

        if (state_q == S_DISP) begin
            if (coin != '0) begin
                rej_d    = 1'b1;
                chv_d    = 1'b1;
                change_d = coin;
            end
            if (cnt_q == CNT_ONE) begin
                state_d = S_IDLE;
            end else begin
                cnt_d = cnt_q - CNT_ONE;
                // Register the refund so it lands in the final busy cycle
                if (cnt_d == CNT_ONE) begin
                    drink_d  = slot_q;
                    chv_d    = 1'b1;
                    change_d = change_d + pend_q;
                end
            end
        end else begin
            if (cancel) begin
                change_d = credit_q + coin;
                chv_d    = 1'b1;
                credit_d = '0;
            end else if (vend_ok) begin
                for (int k = 0; k < NUM_DRINKS; k++) begin
                    if (drink_choose == SEL_W'(k + 1))
                        stock_d[k] = stock_q[k] - STOCK_W'(1);
                end
                pend_d   = credit_q + coin - sel_price;
                slot_d   = drink_choose;
                credit_d = '0;
                cnt_d    = CNT_INIT;
                state_d  = S_DISP;
                if (DISP_CYC == 1) begin
                    drink_d  = drink_choose;
                    chv_d    = 1'b1;
                    change_d = pend_d;
                end
            end else begin
                if (drink_choose != '0)
                    serr_d = 1'b1;
                if (coin != '0) begin
                    if (sum <= MAX_C) begin
                        credit_d = sum[W-1:0];
                    end else begin
                        rej_d    = 1'b1;
                        chv_d    = 1'b1;
                        change_d = coin;
                    end
                end
            end
            if (state_d != S_DISP)
                state_d = (credit_d != '0) ? S_CREDIT : S_IDLE;
        end

        // Refill wins over a same-cycle decrement of the same slot
        for (int k = 0; k < NUM_DRINKS; k++) begin
            if (restock && restock_sel == SEL_W'(k + 1))
                stock_d[k] = STOCK_FULL;
        end

        busy_d = state_d == S_DISP;
        for (int k = 0; k < NUM_DRINKS; k++) begin
            sold_d[k]  = stock_d[k] == '0;
            avail_d[k] = (credit_d >= PRICES[k*W +: W]) && (stock_d[k] != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            credit_q <= '0;
            pend_q   <= '0;
            slot_q   <= '0;
            cnt_q    <= '0;
            for (int k = 0; k < NUM_DRINKS; k++)
                stock_q[k] <= STOCK_FULL;
            change_q <= '0;
            chv_q    <= 1'b0;
            drink_q  <= '0;
            busy_q   <= 1'b0;
            rej_q    <= 1'b0;
            serr_q   <= 1'b0;
            avail_q  <= '0;
            sold_q   <= '0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            pend_q   <= pend_d;
            slot_q   <= slot_d;
            cnt_q    <= cnt_d;
            stock_q  <= stock_d;
            change_q <= change_d;
            chv_q    <= chv_d;
            drink_q  <= drink_d;
            busy_q   <= busy_d;
            rej_q    <= rej_d;
            serr_q   <= serr_d;
            avail_q  <= avail_d;
            sold_q   <= sold_d;
        end
    end

    assign total_coin   = credit_q;
    assign change       = change_q;
    assign change_valid = chv_q;
    assign drink_out    = drink_q;
    assign busy         = busy_q;
    assign coin_reject  = rej_q;
    assign sel_err      = serr_q;
    assign avail        = avail_q;
    assign sold_out     = sold_q;

endmodule

// File: tb/tb_vending_fsm_multi.sv
// Bench for vending_fsm_multi: directed scenarios plus random traffic,
// all checked cycle by cycle against a timeline-based reference model.
module tb_vending_fsm_multi;

    localparam int D = 2;
    localparam int P[4] = '{10, 15, 20, 25};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] coin = '0;
    logic [2:0]  drink_choose = '0;
    logic        cancel = 1'b0;
    logic        restock = 1'b0;
    logic [2:0]  restock_sel = '0;
    logic [31:0] total_coin;
    logic [31:0] change;
    logic        change_valid;
    logic [2:0]  drink_out;
    logic        busy;
    logic        coin_reject;
    logic        sel_err;
    logic [3:0]  avail;
    logic [3:0]  sold_out;

    vending_fsm_multi dut (
        .clk          (clk),
        .reset        (reset),
        .coin         (coin),
        .drink_choose (drink_choose),
        .cancel       (cancel),
        .restock      (restock),
        .restock_sel  (restock_sel),
        .total_coin   (total_coin),
        .change       (change),
        .change_valid (change_valid),
        .drink_out    (drink_out),
        .busy         (busy),
        .coin_reject  (coin_reject),
        .sel_err      (sel_err),
        .avail        (avail),
        .sold_out     (sold_out)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d want=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: credit as an integer, stock per slot, and a dispense
    // timeline anchored at the edge the vend was accepted.
    int  credit, pend, pslot, vedge, t;
    bit  vending;
    int  stock[4];
    int  e_chg, e_drink;
    bit  e_cv, e_busy, e_rej, e_serr;
    logic [3:0] e_avail, e_sold;

    function automatic void model();
        int  k;
        bit  ok;
        t++;
        e_chg = 0; e_cv = 0; e_drink = 0; e_rej = 0; e_serr = 0;
        if (reset) begin
            credit = 0;
            vending = 0;
            for (int i = 0; i < 4; i++) stock[i] = 8;
        end else begin
            if (vending) begin
                if (coin != 0) begin
                    e_rej = 1; e_cv = 1; e_chg = int'(coin);
                end
                if (t - vedge == D - 1) begin
                    e_drink = pslot; e_cv = 1; e_chg += pend;
                end
                if (t - vedge == D) vending = 0;
            end else begin
                k = int'(drink_choose);
                ok = k >= 1 && k <= 4 && credit >= P[(k >= 1 && k <= 4) ? k - 1 : 0]
                     && stock[(k >= 1 && k <= 4) ? k - 1 : 0] > 0;
                if (cancel) begin
                    e_chg = credit + int'(coin); e_cv = 1; credit = 0;
                end else if (ok) begin
                    stock[k-1]--;
                    pend = credit + int'(coin) - P[k-1];
                    pslot = k;
                    credit = 0;
                    vending = 1;
                    vedge = t;
                end else begin
                    if (k != 0) e_serr = 1;
                    if (coin != 0) begin
                        if (credit + int'(coin) <= 100) credit += int'(coin);
                        else begin
                            e_rej = 1; e_cv = 1; e_chg = int'(coin);
                        end
                    end
                end
            end
            if (restock && restock_sel >= 1 && restock_sel <= 4)
                stock[restock_sel-1] = 8;
        end
        e_busy = vending && (t - vedge < D);
        for (int i = 0; i < 4; i++) begin
            e_sold[i]  = stock[i] == 0;
            e_avail[i] = credit >= P[i] && stock[i] > 0;
        end
    endfunction

    task automatic step(input int c, input int ch = 0, input bit cn = 0,
                        input bit rs = 0, input int rsel = 0, input bit rst = 0);
        coin = 32'(c);
        drink_choose = 3'(ch);
        cancel = cn;
        restock = rs;
        restock_sel = 3'(rsel);
        reset = rst;
        @(posedge clk);
        model();
        @(negedge clk);
        chk("total_coin", total_coin, credit);
        chk("change", change, e_chg);
        chk("change_valid", change_valid, e_cv);
        chk("drink_out", drink_out, e_drink);
        chk("busy", busy, e_busy);
        chk("coin_reject", coin_reject, e_rej);
        chk("sel_err", sel_err, e_serr);
        chk("avail", avail, e_avail);
        chk("sold_out", sold_out, e_sold);
    endtask

    initial begin
        t = 0;
        vending = 0;
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        chk("rst_credit", total_coin, 0);
        chk("rst_avail", avail, 0);
        chk("rst_sold", sold_out, 0);

        step(10); step(5); step(1); step(10);
        chk("tp_credit26", total_coin, 26);
        chk("tp_avail_all", avail, 4'hf);
        step(0, 3);
        chk("tp_busy1", busy, 1);
        step(0);
        chk("tp_drink3", drink_out, 3);
        chk("tp_change6", change, 6);
        step(0);
        chk("tp_idle", busy, 0);

        step(10); step(10); step(5); step(1);
        step(5, 0, 1);
        chk("tp_cancel31", change, 31);
        step(0);
        chk("tp_cancel_pulse", change_valid, 0);

        repeat (9) step(10);
        step(20);
        chk("tp_reject", coin_reject, 1);
        chk("tp_reject_chg", change, 20);
        chk("tp_hold90", total_coin, 90);
        step(0, 0, 1);

        step(10); step(2); step(0, 2);
        chk("tp_selerr_credit", sel_err, 1);
        chk("tp_credit12", total_coin, 12);
        step(0, 5);
        chk("tp_selerr_range", sel_err, 1);
        step(0, 0, 1);

        repeat (8) begin
            step(10); step(0, 1); step(0); step(0);
        end
        chk("tp_soldout", sold_out[0], 1);
        step(10); step(0, 1);
        chk("tp_soldout_err", sel_err, 1);
        step(0, 0, 0, 1, 1);
        chk("tp_restock", sold_out[0], 0);
        step(0, 1, 0, 1, 1);
        step(0); step(0);

        step(10); step(0, 1); step(10);
        chk("tp_busy_reject", coin_reject, 1);
        step(0); step(0);
        step(10); step(0, 1);
        step(0, 0, 0, 0, 0, 1);
        chk("tp_rst_nodrink", drink_out, 0);
        chk("tp_rst_busy", busy, 0);
        step(0);

        for (int i = 0; i < 4000; i++) begin
            int sel;
            int cv;
            sel = int'($urandom_range(0, 7));
            cv = (sel < 4) ? 0 : (sel == 4) ? 1 : (sel == 5) ? 5 :
                 (sel == 6) ? 10 : 25;
            step(cv,
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : 0,
                 $urandom_range(0, 24) == 0,
                 $urandom_range(0, 60) == 0,
                 int'($urandom_range(0, 7)),
                 $urandom_range(0, 300) == 0);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
